// File: rtl/skid_buffer_struct_pkg.sv
// Shared types for the skid buffer: occupancy state encoding and an example
// tagged payload that stream stages can carry through the buffer.
package skid_buffer_struct_pkg;

    // Bit 0 = main entry valid, bit 1 = skid entry valid, so the handshake
    // outputs are taken straight from state flops.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    typedef struct packed {
        logic [3:0]  tag;
        logic [15:0] d;
    } tagged_word_t;

endpackage

// File: rtl/skid_buffer_struct_reg.sv
// Enable-load register with asynchronous clear, used for both the main and
// the skid payload entries of the skid buffer.
module skid_reg #(
    parameter type T = logic [7:0]
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  T     d,
    output T     q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/skid_buffer_struct.sv
// Two-entry valid/ready register slice: registers the forward valid/data path
// and the backward ready path while sustaining one transfer per cycle.
module skid_buffer_struct
    import skid_buffer_struct_pkg::*;
#(
    parameter type T = logic [7:0]
) (
    input  logic clk,
    input  logic reset,
    input  logic valid_in,
    output logic ready_in,
    input  T     data_in,
    output logic valid_out,
    input  logic ready_out,
    output T     data_out
);

    state_t     state;
    state_t     state_next;
    logic [1:0] state_bits;
    logic       skid_valid;
    logic       accept;
    logic       fire;
    logic       main_load;
    logic       main_from_skid;
    logic       skid_load;
    T           main_d;
    T           skid_q;

    assign state_bits = state;
    assign valid_out  = state_bits[0];
    assign skid_valid = state_bits[1];
    assign ready_in   = !skid_valid;

    assign accept = valid_in && ready_in;
    assign fire   = valid_out && ready_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next = ONE;
                    main_load  = 1'b1;
                end
            end
            ONE: begin
                // Simultaneous in/out keeps occupancy at one: refill main directly.
                if (accept && fire) begin
                    main_load = 1'b1;
                end else if (accept) begin
                    state_next = FULL;
                    skid_load  = 1'b1;
                end else if (fire) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (fire) begin
                    state_next     = ONE;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    assign main_d = main_from_skid ? skid_q : data_in;

    skid_reg #(.T(T)) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load),
        .d     (main_d),
        .q     (data_out)
    );

    skid_reg #(.T(T)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .d     (data_in),
        .q     (skid_q)
    );

`ifndef SYNTHESIS
    a_hold_stable : assert property (@(posedge clk) disable iff (reset)
        (valid_out && !ready_out) |=> (valid_out && $stable(data_out)))
        else $error("skid_buffer_struct: output changed while stalled");

    a_skid_implies_main : assert property (@(posedge clk) disable iff (reset)
        skid_valid |-> valid_out)
        else $error("skid_buffer_struct: skid entry held without main entry");
`endif

endmodule

// File: tb/tb_skid_buffer_struct.sv
// Scoreboard bench for skid_buffer_struct: byte stream plus a struct payload.
module tb_skid_buffer_struct;
    import skid_buffer_struct_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       valid_in, ready_in, valid_out, ready_out;
    logic [7:0] data_in, data_out;

    logic         s_valid_in, s_ready_in, s_valid_out, s_ready_out;
    tagged_word_t s_data_in, s_data_out;

    int         errors = 0;
    int         checks = 0;
    int         pops = 0;
    int         cyc = 0;
    logic [7:0] sb[$];

    skid_buffer_struct #(.T(logic [7:0])) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .data_out  (data_out)
    );

    skid_buffer_struct #(.T(tagged_word_t)) dut_s (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (s_valid_in),
        .ready_in  (s_ready_in),
        .data_in   (s_data_in),
        .valid_out (s_valid_out),
        .ready_out (s_ready_out),
        .data_out  (s_data_out)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: sees the handshakes that will complete at the next posedge.
    always @(negedge clk) begin
        if (!reset) begin
            if (valid_out && ready_out) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_extra: got %0h expected no output", data_out);
                end else begin
                    chk("sb_order", 32'(data_out), 32'(sb.pop_front()));
                end
                pops++;
            end
            if (valid_in && ready_in) sb.push_back(data_in);
        end
    end

    task automatic send(input logic [7:0] v);
        int n = 0;
        valid_in = 1'b1;
        data_in  = v;
        @(negedge clk);
        while (!ready_in && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!ready_in) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: ready_in=%0d expected 1", ready_in);
            valid_in = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            valid_in = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        ready_out = 1'b1;
        while ((sb.size() != 0 || valid_out) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
        chk({name, "_idle"}, 32'(valid_out), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t1 [3];
        int         c0;
        int         p0;
        bit         done;
        t1 = '{8'hA0, 8'hA1, 8'hA2};

        reset       = 1'b1;
        valid_in    = 1'b0;
        data_in     = 8'h00;
        ready_out   = 1'b1;
        s_valid_in  = 1'b0;
        s_data_in   = '0;
        s_ready_out = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_ready_in", 32'(ready_in), 32'd1);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_s_data_out", 32'(s_data_out), 32'd0);
        reset = 1'b0;

        // Test 1: single items, one cycle latency, data held after leaving
        for (int i = 0; i < 3; i++) begin
            send(t1[i]);
            chk("t1_valid", 32'(valid_out), 32'd1);
            chk("t1_data", 32'(data_out), 32'(t1[i]));
            @(posedge clk);
            #1;
            chk("t1_empty", 32'(valid_out), 32'd0);
            chk("t1_hold", 32'(data_out), 32'(t1[i]));
        end
        drain("t1");

        // Test 2: back-to-back at full rate
        @(posedge clk);
        #1;
        c0 = cyc;
        p0 = pops;
        for (int i = 0; i < 8; i++) begin
            send(8'h10 + 8'(i));
            chk("t2_ready", 32'(ready_in), 32'd1);
        end
        chk("t2_cycles", 32'(cyc - c0), 32'd8);
        drain("t2");
        chk("t2_count", 32'(pops - p0), 32'd8);

        // Test 3: stall fills main and skid, third item held off
        @(posedge clk);
        #1;
        ready_out = 1'b0;
        send(8'h20);
        send(8'h21);
        chk("t3_ready_low", 32'(ready_in), 32'd0);
        chk("t3_valid", 32'(valid_out), 32'd1);
        chk("t3_main", 32'(data_out), 32'h20);
        valid_in = 1'b1;
        data_in  = 8'h22;
        repeat (3) @(posedge clk);
        #1;
        chk("t3_still_low", 32'(ready_in), 32'd0);
        chk("t3_main_stable", 32'(data_out), 32'h20);
        chk("t3_inflight", 32'(sb.size()), 32'd2);
        ready_out = 1'b1;
        send(8'h22);
        drain("t3");

        // Test 4: random valid gaps and random backpressure
        p0   = pops;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send(8'(i * 37 + 3));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    ready_out = 1'($urandom_range(0, 1));
                end
            end
        join
        drain("t4");
        chk("t4_count", 32'(pops - p0), 32'd1000);

        // Test 5: asynchronous reset while FULL
        @(posedge clk);
        #1;
        ready_out = 1'b0;
        send(8'h30);
        send(8'h31);
        valid_in = 1'b1;
        data_in  = 8'h32;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("t5_valid_out", 32'(valid_out), 32'd0);
        chk("t5_ready_in", 32'(ready_in), 32'd1);
        chk("t5_data_out", 32'(data_out), 32'd0);
        valid_in = 1'b0;
        sb.delete();
        @(posedge clk);
        #2;
        chk("t5_held", 32'(valid_out), 32'd0);
        reset     = 1'b0;
        ready_out = 1'b1;
        p0        = pops;
        send(8'h55);
        chk("t5_new_valid", 32'(valid_out), 32'd1);
        chk("t5_new_data", 32'(data_out), 32'h55);
        drain("t5");
        chk("t5_count", 32'(pops - p0), 32'd1);

        // Test 6: struct payload copied bit-exact
        @(posedge clk);
        #1;
        s_valid_in = 1'b1;
        s_data_in  = '{tag: 4'h3, d: 16'hBEEF};
        @(negedge clk);
        chk("t6_ready", 32'(s_ready_in), 32'd1);
        @(posedge clk);
        #1;
        s_valid_in = 1'b0;
        chk("t6_valid", 32'(s_valid_out), 32'd1);
        chk("t6_data", 32'(s_data_out), 32'h3BEEF);
        chk("t6_tag", 32'(s_data_out.tag), 32'h3);
        @(posedge clk);
        #1;
        chk("t6_empty", 32'(s_valid_out), 32'd0);
        chk("t6_hold", 32'(s_data_out), 32'h3BEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
